ccc_decoder_stream: RTL and testbench

CCC_DECODER_STREAM -- requirements
Module: ccc_decoder_stream

---
 rtl/ccc_decoder_stream_pkg.sv | 15 +
 rtl/ccc_decoder_stream_if.sv | 27 ++
 rtl/ccc_decoder_stream_row_expand.sv | 15 +
 rtl/ccc_decoder_stream.sv | 70 +++++++
 tb/tb_ccc_decoder_stream.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ccc_decoder_stream_pkg.sv
// ccc_pkg: shared state type, default parameters and encoded-block field offsets for ccc_decoder_stream.
package ccc_pkg;
   typedef enum logic {IDLE, EMIT} state_t;
   localparam int DEF_BLK_W = 4;
   localparam int DEF_BLK_H = 4;
   localparam int DEF_CH_BITS = 8;
   localparam int DEF_CNT_W = 16;
   function automatic int bitmap_lsb(input int ch_bits);
      return 6 * ch_bits;
   endfunction
   // bucket 0 sits above bucket 1; each bucket is {r,g,b}, already in pixel order
   function automatic int bucket_lsb(input int ch_bits, input int b);
      return (1 - b) * 3 * ch_bits;
   endfunction
endpackage

// File: rtl/ccc_decoder_stream_if.sv
// ccc_decoder_stream_if: encoded-block input stream, decoded-row output stream and block counter.
interface ccc_decoder_stream_if import ccc_pkg::*; #(
   parameter int BLK_W = DEF_BLK_W,
   parameter int BLK_H = DEF_BLK_H,
   parameter int CH_BITS = DEF_CH_BITS,
   parameter int CNT_W = DEF_CNT_W
);
   localparam int PIX_BITS = 3 * CH_BITS;
   localparam int BLK_BITS = BLK_W * BLK_H + 6 * CH_BITS;
   logic [BLK_BITS-1:0] in_data;
   logic in_mode;
   logic in_valid;
   logic in_ready;
   logic [BLK_W*PIX_BITS-1:0] out_row;
   logic out_valid;
   logic out_last;
   logic out_ready;
   logic [CNT_W-1:0] blk_count;
   modport master (
      output in_data, in_mode, in_valid, out_ready,
      input in_ready, out_row, out_valid, out_last, blk_count
   );
   modport slave (
      input in_data, in_mode, in_valid, out_ready,
      output in_ready, out_row, out_valid, out_last, blk_count
   );
endinterface

// File: rtl/ccc_decoder_stream_row_expand.sv
// ccc_row_expand: expands one bitmap row into pixels, picking bucket 1 for set bits unless solid mode.
module ccc_row_expand #(
   parameter int BLK_W = 4,
   parameter int PIX_BITS = 24
) (
   input  logic [BLK_W-1:0] bits,
   input  logic [PIX_BITS-1:0] b0,
   input  logic [PIX_BITS-1:0] b1,
   input  logic mode,
   output logic [BLK_W*PIX_BITS-1:0] row
);
   for (genvar i = 0; i < BLK_W; i++) begin : g_pix
      assign row[i*PIX_BITS +: PIX_BITS] = (bits[i] && !mode) ? b1 : b0;
   end
endmodule

// File: rtl/ccc_decoder_stream.sv
// ccc_decoder_stream: decodes two-colour compressed blocks into a registered stream of pixel rows.
module ccc_decoder_stream import ccc_pkg::*; #(
   parameter int BLK_W = DEF_BLK_W,
   parameter int BLK_H = DEF_BLK_H,
   parameter int CH_BITS = DEF_CH_BITS,
   parameter int CNT_W = DEF_CNT_W
) (
   input logic clk,
   input logic rst_n,
   ccc_decoder_stream_if.slave s
);
   localparam int PIX_BITS = 3 * CH_BITS;
   localparam int NPIX = BLK_W * BLK_H;
   localparam int BLK_BITS = NPIX + 6 * CH_BITS;
   localparam int RW = BLK_H > 1 ? $clog2(BLK_H) : 1;
   localparam int BM_LSB = bitmap_lsb(CH_BITS);
   localparam int B0_LSB = bucket_lsb(CH_BITS, 0);
   localparam int B1_LSB = bucket_lsb(CH_BITS, 1);
   state_t state, state_nx;
   logic [RW-1:0] row;
   logic [BLK_BITS-1:0] hold_data, src;
   logic hold_mode, src_mode, last, in_xfer, out_xfer;
   logic [NPIX-1:0] bm;
   logic [BLK_W-1:0] bits;
   logic [BLK_W*PIX_BITS-1:0] row_nx;
   int ridx;
   assign last = row == RW'(BLK_H - 1);
   assign s.out_valid = state == EMIT;
   assign s.out_last = s.out_valid && last;
   assign s.in_ready = rst_n && (state == IDLE || (s.out_last && s.out_ready));
   assign in_xfer = s.in_valid && s.in_ready;
   assign out_xfer = s.out_valid && s.out_ready;
   always_comb state_nx = in_xfer ? EMIT : (out_xfer && last) ? IDLE : state;
   // the next registered row comes from the incoming block on accept, else the held block
   always_comb begin
      src = in_xfer ? s.in_data : hold_data;
      src_mode = in_xfer ? s.in_mode : hold_mode;
      ridx = in_xfer ? 0 : int'(row) + 1;
      bm = src[BM_LSB +: NPIX];
      bits = BLK_W'(bm >> (ridx * BLK_W));
   end
   ccc_row_expand #(.BLK_W(BLK_W), .PIX_BITS(PIX_BITS)) u_expand (
      .bits(bits),
      .b0(src[B0_LSB +: PIX_BITS]),
      .b1(src[B1_LSB +: PIX_BITS]),
      .mode(src_mode),
      .row(row_nx)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row <= '0;
         hold_data <= '0;
         hold_mode <= 1'b0;
         s.out_row <= '0;
         s.blk_count <= '0;
      end else begin
         if (in_xfer) begin
            hold_data <= s.in_data;
            hold_mode <= s.in_mode;
         end
         if (in_xfer) row <= '0;
         else if (out_xfer) row <= last ? '0 : row + RW'(1);
         if (in_xfer || (out_xfer && !last)) s.out_row <= row_nx;
         if (out_xfer && last) s.blk_count <= s.blk_count + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_ccc_decoder_stream.sv
// tb_ccc_decoder_stream: self-checking bench for ccc_decoder_stream against a pixel-level block model.
module tb_ccc_decoder_stream;
   logic clk = 0, rst_n, rst2_n;
   int errors = 0, checks = 0, exp_bc = 0;
   always #5 clk = ~clk;
   ccc_decoder_stream_if if0();
   ccc_decoder_stream_if #(.CNT_W(2)) if1();
   ccc_decoder_stream u0 (.clk(clk), .rst_n(rst_n), .s(if0));
   ccc_decoder_stream #(.CNT_W(2)) u1 (.clk(clk), .rst_n(rst2_n), .s(if1));
   localparam logic [63:0] BLK_A = {16'h00FF, 24'h102030, 24'hA0B0C0};
   localparam logic [95:0] ROW_B0 = {4{24'h102030}};
   localparam logic [95:0] ROW_B1 = {4{24'hA0B0C0}};

   // pixel (y,x) takes bucket 1 only for a set bitmap bit in two-colour mode
   function automatic logic [95:0] exp_row(input logic [63:0] d, input logic m, input int y);
      logic [15:0] bm;
      logic [95:0] r;
      bm = d[63:48];
      for (int x = 0; x < 4; x++) r[x*24 +: 24] = (!m && bm[y*4+x]) ? d[23:0] : d[47:24];
      return r;
   endfunction

   task automatic send(input logic [63:0] d, input logic m);
      int n = 0;
      @(negedge clk);
      if0.in_valid = 1; if0.in_data = d; if0.in_mode = m;
      #1;
      while (!if0.in_ready && n < 50) begin @(negedge clk); #1; n++; end
      checks++;
      if (n == 50) begin errors++; $display("FAIL send_timeout in_ready=%b required 1", if0.in_ready); end
      @(negedge clk);
      if0.in_valid = 0;
   endtask

   task automatic test_reset;
      rst_n = 0; rst2_n = 0;
      if0.in_valid = 0; if0.in_mode = 0; if0.in_data = '0; if0.out_ready = 0;
      if1.in_valid = 0; if1.in_mode = 0; if1.in_data = '0; if1.out_ready = 0;
      repeat (2) @(negedge clk);
      #1;
      checks += 5;
      if (if0.out_valid !== 0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", if0.out_valid); end
      if (if0.out_last !== 0) begin errors++; $display("FAIL reset_out_last got=%b exp=0", if0.out_last); end
      if (if0.out_row !== '0) begin errors++; $display("FAIL reset_out_row got=%h exp=0", if0.out_row); end
      if (if0.blk_count !== 16'd0) begin errors++; $display("FAIL reset_blk_count got=%0d exp=0", if0.blk_count); end
      if (if0.in_ready !== 0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", if0.in_ready); end
      @(negedge clk);
      rst_n = 1; rst2_n = 1; exp_bc = 0;
      #1;
      checks++;
      if (if0.in_ready !== 1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", if0.in_ready); end
   endtask

   task automatic test_fixed_block(input logic m);
      if0.out_ready = 1;
      send(BLK_A, m);
      for (int y = 0; y < 4; y++) begin
         #1;
         checks += 3;
         if (if0.out_valid !== 1) begin errors++; $display("FAIL fixed_m%0d_valid row=%0d got=%b exp=1", m, y, if0.out_valid); end
         if (if0.out_row !== ((m || y >= 2) ? ROW_B0 : ROW_B1))
            begin errors++; $display("FAIL fixed_m%0d_row row=%0d got=%h exp=%h", m, y, if0.out_row, (m || y >= 2) ? ROW_B0 : ROW_B1); end
         if (if0.out_last !== (y == 3)) begin errors++; $display("FAIL fixed_m%0d_last row=%0d got=%b exp=%b", m, y, if0.out_last, y == 3); end
         @(negedge clk);
      end
      exp_bc++;
      #1;
      checks += 2;
      if (if0.out_valid !== 0) begin errors++; $display("FAIL fixed_m%0d_idle got=%b exp=0", m, if0.out_valid); end
      if (if0.blk_count !== 16'(exp_bc)) begin errors++; $display("FAIL fixed_m%0d_count got=%0d exp=%0d", m, if0.blk_count, exp_bc); end
   endtask

   task automatic test_stall;
      int pat[4] = '{1, 0, 0, 1};
      int y = 0, cyc = 0;
      logic stalled = 0;
      logic [95:0] held = '0;
      logic [63:0] d = {$urandom, $urandom};
      send(d, 0);
      while (y < 4 && cyc < 40) begin
         if0.out_ready = pat[cyc % 4][0];
         #1;
         if (stalled) begin
            checks++;
            if (if0.out_row !== held || if0.out_valid !== 1)
               begin errors++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", cyc, if0.out_row, held); end
         end
         if (if0.out_valid && if0.out_ready) begin
            checks += 2;
            if (if0.out_row !== exp_row(d, 0, y)) begin errors++; $display("FAIL stall_row row=%0d got=%h exp=%h", y, if0.out_row, exp_row(d, 0, y)); end
            if (if0.out_last !== (y == 3)) begin errors++; $display("FAIL stall_last row=%0d got=%b exp=%b", y, if0.out_last, y == 3); end
            y++;
         end
         stalled = if0.out_valid && !if0.out_ready;
         held = if0.out_row;
         cyc++;
         @(negedge clk);
      end
      exp_bc++;
      if0.out_ready = 1;
      #1;
      checks += 2;
      if (y != 4 || cyc != 8) begin errors++; $display("FAIL stall_transfers got=%0d in %0d cycles exp=4 in 8", y, cyc); end
      if (if0.out_valid !== 0) begin errors++; $display("FAIL stall_extra_row got=%b exp=0", if0.out_valid); end
   endtask

   task automatic test_back_to_back;
      logic [63:0] d[2];
      d[0] = {$urandom, $urandom}; d[1] = {$urandom, $urandom};
      if0.out_ready = 1;
      @(negedge clk);
      if0.in_valid = 1; if0.in_data = d[0]; if0.in_mode = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if0.in_valid = k < 4; if0.in_data = d[1];
         #1;
         checks += 3;
         if (if0.out_valid !== 1) begin errors++; $display("FAIL b2b_gap beat=%0d got=%b exp=1", k, if0.out_valid); end
         if (if0.out_row !== exp_row(d[k/4], 0, k % 4)) begin errors++; $display("FAIL b2b_row beat=%0d got=%h exp=%h", k, if0.out_row, exp_row(d[k/4], 0, k % 4)); end
         if (if0.in_ready !== (k % 4 == 3)) begin errors++; $display("FAIL b2b_in_ready beat=%0d got=%b exp=%b", k, if0.in_ready, k % 4 == 3); end
      end
      exp_bc += 2;
      @(negedge clk);
      if0.in_valid = 0;
      #1;
      checks += 2;
      if (if0.out_valid !== 0) begin errors++; $display("FAIL b2b_end got=%b exp=0", if0.out_valid); end
      if (if0.blk_count !== 16'(exp_bc)) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", if0.blk_count, exp_bc); end
   endtask

   task automatic test_random_stream;
      logic [95:0] q_row[$];
      logic q_last[$];
      logic [95:0] held = '0;
      logic held_last = 0, stalled = 0, m = 0;
      logic [63:0] d = {$urandom, $urandom};
      int sent = 0, cyc = 0;
      while ((sent < 6 || q_row.size() > 0) && cyc < 400) begin
         @(negedge clk);
         if0.in_valid = sent < 6 && $urandom_range(0, 2) != 0;
         if0.in_data = d; if0.in_mode = m;
         if0.out_ready = $urandom_range(0, 3) != 0;
         #1;
         if (stalled) begin
            checks++;
            if (if0.out_row !== held || if0.out_last !== held_last || if0.out_valid !== 1)
               begin errors++; $display("FAIL rand_hold cyc=%0d got=%h exp=%h", cyc, if0.out_row, held); end
         end
         if (if0.in_valid && if0.in_ready) begin
            for (int y = 0; y < 4; y++) begin q_row.push_back(exp_row(d, m, y)); q_last.push_back(y == 3); end
            sent++;
            d = {$urandom, $urandom}; m = $urandom_range(0, 3) == 0;
         end
         if (if0.out_valid && if0.out_ready) begin
            checks++;
            if (q_row.size() == 0) begin errors++; $display("FAIL rand_unexpected cyc=%0d got=%h exp=none", cyc, if0.out_row); end
            else begin
               if (if0.out_row !== q_row[0] || if0.out_last !== q_last[0])
                  begin errors++; $display("FAIL rand_row cyc=%0d got=%h/%b exp=%h/%b", cyc, if0.out_row, if0.out_last, q_row[0], q_last[0]); end
               void'(q_row.pop_front()); void'(q_last.pop_front());
            end
         end
         stalled = if0.out_valid && !if0.out_ready;
         held = if0.out_row; held_last = if0.out_last;
         cyc++;
      end
      exp_bc += 6;
      @(negedge clk);
      if0.in_valid = 0;
      #1;
      checks += 2;
      if (sent != 6 || q_row.size() != 0) begin errors++; $display("FAIL rand_drain sent=%0d left=%0d exp 6/0", sent, q_row.size()); end
      if (if0.blk_count !== 16'(exp_bc)) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", if0.blk_count, exp_bc); end
   endtask

   task automatic test_reset_mid_block;
      logic [63:0] d2 = {$urandom, $urandom};
      if0.out_ready = 1;
      send({$urandom, $urandom}, 0);
      @(negedge clk);
      @(negedge clk);
      if0.out_ready = 0;
      #3;
      rst_n = 0;
      #1;
      checks += 3;
      if (if0.out_valid !== 0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", if0.out_valid); end
      if (if0.blk_count !== 16'd0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", if0.blk_count); end
      if (if0.out_row !== '0) begin errors++; $display("FAIL midrst_row got=%h exp=0", if0.out_row); end
      @(negedge clk);
      rst_n = 1; exp_bc = 0;
      if0.out_ready = 1;
      @(negedge clk);
      #1;
      checks++;
      if (if0.out_valid !== 0) begin errors++; $display("FAIL midrst_leftover got=%b exp=0", if0.out_valid); end
      send(d2, 0);
      for (int y = 0; y < 4; y++) begin
         #1;
         checks++;
         if (if0.out_row !== exp_row(d2, 0, y) || if0.out_valid !== 1)
            begin errors++; $display("FAIL midrst_row%0d got=%h exp=%h", y, if0.out_row, exp_row(d2, 0, y)); end
         @(negedge clk);
      end
      exp_bc++;
      #1;
      checks++;
      if (if0.blk_count !== 16'(exp_bc)) begin errors++; $display("FAIL midrst_count_after got=%0d exp=%0d", if0.blk_count, exp_bc); end
   endtask

   task automatic test_count_wrap;
      @(negedge clk);
      if1.in_valid = 1; if1.in_data = {$urandom, $urandom}; if1.out_ready = 1;
      #1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if1.in_valid = k < 16; if1.in_data = {$urandom, $urandom};
         #1;
         checks++;
         if (if1.out_valid !== 1) begin errors++; $display("FAIL wrap_gap beat=%0d got=%b exp=1", k, if1.out_valid); end
         if (k % 4 == 0) begin
            checks++;
            if (if1.blk_count !== 2'((k / 4) % 4)) begin errors++; $display("FAIL wrap_count beat=%0d got=%0d exp=%0d", k, if1.blk_count, (k / 4) % 4); end
         end
      end
      @(negedge clk);
      if1.in_valid = 0;
      #1;
      checks += 2;
      if (if1.blk_count !== 2'(5 % 4)) begin errors++; $display("FAIL wrap_final got=%0d exp=%0d", if1.blk_count, 5 % 4); end
      if (if1.out_valid !== 0) begin errors++; $display("FAIL wrap_idle got=%b exp=0", if1.out_valid); end
   endtask

   initial begin
      test_reset();
      test_fixed_block(0);
      test_fixed_block(1);
      test_stall();
      test_back_to_back();
      test_random_stream();
      test_reset_mid_block();
      test_count_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
